// File: rtl/regfile_write_sched.sv
// Round-robin scheduler sharing the register file write port among NREQ requesters.
// Optional macro REG0_DISCARD_EN: writes to register 0 are accepted but silently consumed.
module regfile_write_sched #(
   parameter int NREQ   = 2,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*5-1:0]      req_addr,
   input  logic [NREQ*DATA_W-1:0] req_data,
   input  logic                   wr_stall,
   output logic                   wr_en,
   output logic [31:0]            wr_sel,
   output logic [DATA_W-1:0]      wr_data,
   output logic [1:0]             wr_gnt_id,
   output logic                   wr_ovr
);

`ifdef REG0_DISCARD_EN
   localparam bit DISCARD_R0 = 1'b1;
`else
   localparam bit DISCARD_R0 = 1'b0;
`endif

   logic              wr_en_q;
   logic [31:0]       wr_sel_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [1:0]        wr_gnt_id_q;
   logic              wr_ovr_q;
   logic [1:0]        ptr_q;

   logic [4:0]        addr_a [4];
   logic [DATA_W-1:0] data_a [4];
   logic [3:0]        valid_pad;
   logic [3:0]        rdy_pad;
   logic [1:0]        win;
   logic [1:0]        idx;
   logic [1:0]        ptr_d;
   logic              found;
   logic              free;
   logic              xfer;
   logic              discard;
   logic [4:0]        win_addr;

   // Pad per-requester slices out to four entries so the winner index is always in range.
   for (genvar g = 0; g < 4; g++) begin : g_slice
      if (g < NREQ) begin : g_used
         assign addr_a[g] = req_addr[5*g +: 5];
         assign data_a[g] = req_data[DATA_W*g +: DATA_W];
      end else begin : g_unused
         assign addr_a[g] = '0;
         assign data_a[g] = '0;
      end
   end

   assign valid_pad = 4'(req_valid);

   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = 2'((int'(ptr_q) + k) % NREQ);
         if (!found && valid_pad[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign free     = !wr_en_q || !wr_stall;
   assign xfer     = found && free && rst_n;
   assign win_addr = addr_a[win];
   assign discard  = DISCARD_R0 && (win_addr == 5'd0);
   assign ptr_d    = 2'((int'(win) + 1) % NREQ);

   always_comb begin
      rdy_pad = '0;
      if (xfer) rdy_pad[win] = 1'b1;
   end

   assign req_ready = rdy_pad[NREQ-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q     <= 1'b0;
         wr_sel_q    <= '0;
         wr_data_q   <= '0;
         wr_gnt_id_q <= '0;
         wr_ovr_q    <= 1'b0;
         ptr_q       <= '0;
      end else if (xfer) begin
         ptr_q <= ptr_d;
         if (discard) begin
            // Slot was free, so any presented write retires this cycle.
            wr_en_q  <= 1'b0;
            wr_sel_q <= '0;
         end else begin
            wr_en_q     <= 1'b1;
            wr_sel_q    <= 32'd1 << win_addr;
            wr_data_q   <= data_a[win];
            wr_gnt_id_q <= win;
            if (win_addr == 5'd0) wr_ovr_q <= 1'b1;
         end
      end else if (wr_en_q && !wr_stall) begin
         wr_en_q  <= 1'b0;
         wr_sel_q <= '0;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_sel    = wr_sel_q;
   assign wr_data   = wr_data_q;
   assign wr_gnt_id = wr_gnt_id_q;
   assign wr_ovr    = wr_ovr_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed self-checking bench for regfile_write_sched (NREQ=2, DATA_W=32).
module tb_regfile_write_sched;
   localparam int NREQ = 2;
   localparam int DW   = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NREQ-1:0]  req_valid = '0;
   logic [NREQ-1:0]  req_ready;
   logic [NREQ*5-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_data = '0;
   logic             wr_stall = 1'b0;
   logic             wr_en;
   logic [31:0]      wr_sel;
   logic [DW-1:0]    wr_data;
   logic [1:0]       wr_gnt_id;
   logic             wr_ovr;

   int checks = 0;
   int failures = 0;

   regfile_write_sched #(.NREQ(NREQ), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .wr_stall(wr_stall),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .wr_gnt_id(wr_gnt_id), .wr_ovr(wr_ovr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      req_addr = '0;
      req_data = '0;
      wr_stall = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 2'b11;
      step();
      checks++;
      if ({wr_en, wr_sel, wr_data, wr_gnt_id, wr_ovr} !== '0) begin
         failures++;
         $display("FAIL reset_outputs en=%0b sel=%h data=%h gnt=%0d ovr=%0b expected all 0",
                  wr_en, wr_sel, wr_data, wr_gnt_id, wr_ovr);
      end
      checks++;
      if (req_ready !== 2'b00) begin
         failures++;
         $display("FAIL reset_ready got=%b expected=00", req_ready);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 2'b01;
      req_addr[4:0] = 5'd5;
      req_data[31:0] = 32'hDEADBEEF;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL single_ready got=%b expected=01", req_ready);
      end
      step();
      req_valid = 2'b00;
      checks++;
      if (wr_en !== 1'b1 || wr_sel !== 32'h0000_0020 || wr_data !== 32'hDEADBEEF || wr_gnt_id !== 2'd0) begin
         failures++;
         $display("FAIL single_present en=%0b sel=%h data=%h gnt=%0d expected 1/00000020/deadbeef/0",
                  wr_en, wr_sel, wr_data, wr_gnt_id);
      end
      step();
      checks++;
      if (wr_en !== 1'b0 || wr_sel !== 32'h0) begin
         failures++;
         $display("FAIL single_empty en=%0b sel=%h expected 0/00000000", wr_en, wr_sel);
      end
   endtask

   task automatic test_contention();
      logic [1:0]  exp_rdy;
      logic [31:0] exp_sel;
      do_reset();
      req_valid = 2'b11;
      req_addr = {5'd31, 5'd3};
      req_data = {32'hBBBB_0001, 32'hAAAA_0000};
      #1;
      for (int i = 0; i < 4; i++) begin
         exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
         checks++;
         if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL contention_ready[%0d] got=%b expected=%b", i, req_ready, exp_rdy);
         end
         step();
         exp_sel = (i % 2 == 0) ? 32'h0000_0008 : 32'h8000_0000;
         checks++;
         if (wr_en !== 1'b1 || wr_gnt_id !== 2'(i % 2) || wr_sel !== exp_sel) begin
            failures++;
            $display("FAIL contention_grant[%0d] en=%0b gnt=%0d sel=%h expected 1/%0d/%h",
                     i, wr_en, wr_gnt_id, wr_sel, i % 2, exp_sel);
         end
      end
      req_valid = 2'b00;
      step();
      checks++;
      if (wr_en !== 1'b0) begin
         failures++;
         $display("FAIL contention_drain en=%0b expected 0", wr_en);
      end
   endtask

   task automatic test_stall();
      do_reset();
      req_valid = 2'b01;
      req_addr = {5'd9, 5'd7};
      req_data = {32'h0000_0099, 32'h0000_0077};
      step();
      req_valid = 2'b10;
      wr_stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wr_en !== 1'b1 || wr_sel !== 32'h0000_0080 || wr_data !== 32'h77 || req_ready !== 2'b00) begin
            failures++;
            $display("FAIL stall_hold[%0d] en=%0b sel=%h data=%h rdy=%b expected 1/00000080/00000077/00",
                     i, wr_en, wr_sel, wr_data, req_ready);
         end
         if (i < 2) step();
      end
      wr_stall = 1'b0;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("FAIL stall_release_ready got=%b expected=10", req_ready);
      end
      step();
      req_valid = 2'b00;
      checks++;
      if (wr_en !== 1'b1 || wr_sel !== 32'h0000_0200 || wr_gnt_id !== 2'd1 || wr_data !== 32'h99) begin
         failures++;
         $display("FAIL stall_next en=%0b sel=%h gnt=%0d data=%h expected 1/00000200/1/00000099",
                  wr_en, wr_sel, wr_gnt_id, wr_data);
      end
      step();
      checks++;
      if (wr_en !== 1'b0 || wr_sel !== 32'h0) begin
         failures++;
         $display("FAIL stall_drain en=%0b sel=%h expected 0/00000000", wr_en, wr_sel);
      end
   endtask

   task automatic test_back_to_back();
      logic        exp_en;
      logic [31:0] exp_sel;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         req_valid = 2'b01;
         req_addr[4:0] = 5'(i);
         req_data[31:0] = 32'(i + 100);
         step();
         exp_sel = 32'd1 << i;
         exp_en = 1'b1;
`ifdef REG0_DISCARD_EN
         if (i == 0) begin
            exp_en = 1'b0;
            exp_sel = 32'h0;
         end
`endif
         checks++;
         if (wr_en !== exp_en || wr_sel !== exp_sel || (exp_en && (wr_data !== 32'(i + 100) || wr_gnt_id !== 2'd0))) begin
            failures++;
            $display("FAIL b2b[%0d] en=%0b sel=%h data=%h gnt=%0d expected %0b/%h/%h/0",
                     i, wr_en, wr_sel, wr_data, wr_gnt_id, exp_en, exp_sel, 32'(i + 100));
         end
      end
      req_valid = 2'b00;
      step();
      checks++;
      if (wr_en !== 1'b0 || wr_sel !== 32'h0) begin
         failures++;
         $display("FAIL b2b_drain en=%0b sel=%h expected 0/00000000", wr_en, wr_sel);
      end
   endtask

   task automatic test_reg0();
      do_reset();
      req_valid = 2'b01;
      req_addr[4:0] = 5'd0;
      req_data[31:0] = 32'h0000_1234;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL reg0_ready got=%b expected=01", req_ready);
      end
      step();
      req_valid = 2'b00;
`ifdef REG0_DISCARD_EN
      checks++;
      if (wr_en !== 1'b0 || wr_sel !== 32'h0 || wr_ovr !== 1'b0) begin
         failures++;
         $display("FAIL reg0_discard en=%0b sel=%h ovr=%0b expected 0/00000000/0", wr_en, wr_sel, wr_ovr);
      end
      step();
      checks++;
      if (wr_ovr !== 1'b0) begin
         failures++;
         $display("FAIL reg0_ovr_clear got=%0b expected=0", wr_ovr);
      end
`else
      checks++;
      if (wr_en !== 1'b1 || wr_sel !== 32'h0000_0001 || wr_data !== 32'h1234 || wr_ovr !== 1'b1) begin
         failures++;
         $display("FAIL reg0_present en=%0b sel=%h data=%h ovr=%0b expected 1/00000001/00001234/1",
                  wr_en, wr_sel, wr_data, wr_ovr);
      end
      step();
      checks++;
      if (wr_ovr !== 1'b1 || wr_en !== 1'b0) begin
         failures++;
         $display("FAIL reg0_ovr_sticky ovr=%0b en=%0b expected 1/0", wr_ovr, wr_en);
      end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 2'b01;
      req_addr = {5'd6, 5'd4};
      req_data = {32'h0000_0066, 32'h0000_0044};
      step();
      // Pointer now 1; stall keeps the write held.
      req_valid = 2'b11;
      wr_stall = 1'b1;
      #1;
      checks++;
      if (wr_en !== 1'b1 || wr_sel !== 32'h0000_0010 || req_ready !== 2'b00) begin
         failures++;
         $display("FAIL midrst_full en=%0b sel=%h rdy=%b expected 1/00000010/00", wr_en, wr_sel, req_ready);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (wr_en !== 1'b0 || wr_sel !== 32'h0 || req_ready !== 2'b00) begin
         failures++;
         $display("FAIL midrst_async en=%0b sel=%h rdy=%b expected 0/00000000/00", wr_en, wr_sel, req_ready);
      end
      step();
      rst_n = 1'b1;
      wr_stall = 1'b0;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL midrst_ready got=%b expected=01", req_ready);
      end
      step();
      req_valid = 2'b00;
      checks++;
      if (wr_en !== 1'b1 || wr_gnt_id !== 2'd0 || wr_sel !== 32'h0000_0010) begin
         failures++;
         $display("FAIL midrst_first_grant en=%0b gnt=%0d sel=%h expected 1/0/00000010", wr_en, wr_gnt_id, wr_sel);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_stall();
      test_back_to_back();
      test_reg0();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
